// File: rtl/id_pipe_stage_if.sv
// Fetch-side, register-file, writeback and execute-side signals of the decode stage.
interface id_pipe_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_inst;
   logic [XLEN-1:0]       in_pc;
   logic [REG_ADDR_W-1:0] raddr1;
   logic [REG_ADDR_W-1:0] raddr2;
   logic [XLEN-1:0]       rdata1;
   logic [XLEN-1:0]       rdata2;
   logic                  wb_we;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [XLEN-1:0]       wb_data;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       out_pc;
   logic [XLEN-1:0]       out_imm;
   logic [XLEN-1:0]       out_rs1_val;
   logic [XLEN-1:0]       out_rs2_val;
   logic [REG_ADDR_W-1:0] out_rs1;
   logic [REG_ADDR_W-1:0] out_rs2;
   logic [REG_ADDR_W-1:0] out_rd;
   logic [6:0]            out_opcode;
   logic [2:0]            out_funct3;
   logic [6:0]            out_funct7;
   logic                  out_is_load;
   logic                  out_illegal;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output in_valid, in_inst, in_pc, rdata1, rdata2, wb_we, wb_rd, wb_data, flush, out_ready,
      input  in_ready, raddr1, raddr2, out_valid, out_pc, out_imm, out_rs1_val, out_rs2_val,
             out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7, out_is_load,
             out_illegal, stall_cnt
   );

   modport slave (
      input  in_valid, in_inst, in_pc, rdata1, rdata2, wb_we, wb_rd, wb_data, flush, out_ready,
      output in_ready, raddr1, raddr2, out_valid, out_pc, out_imm, out_rs1_val, out_rs2_val,
             out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7, out_is_load,
             out_illegal, stall_cnt
   );
endinterface

// File: rtl/id_pipe_stage.sv
// RV32I registered decode stage with load-use bubble insertion and saturating stall counter.
// Optional writeback bypass into captured/held operands: define ID_WB_BYPASS_EN.
module id_pipe_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input logic              clk,
   input logic              rst_n,
   id_pipe_stage_if.slave   bus
);
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] i);
      logic signed [XLEN-1:0] r;
      case (i[6:0])
         OPC_STORE:          r = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
         OPC_BRANCH:         r = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: r = {{(XLEN-31){i[31]}}, i[30:12], 12'b0};
         OPC_JAL:            r = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
         default:            r = {{(XLEN-12){i[31]}}, i[31:20]};
      endcase
      return r;
   endfunction

   function automatic logic is_illegal(input logic [31:0] i);
      return (i[1:0] != 2'b11) ||
             !(i[6:0] inside {OPC_OP, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI,
                              OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_FENCE});
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic wb_hit(input logic we, input logic [REG_ADDR_W-1:0] wrd,
                                   input logic [REG_ADDR_W-1:0] a);
      return we && (wrd != '0) && (wrd == a);
   endfunction

   logic [31:0]            inst;
   logic [6:0]             opc;
   logic [REG_ADDR_W-1:0]  rs1_a, rs2_a, rd_a;
   logic                   uses_rs2, hazard, ready, accept;
   logic signed [XLEN-1:0] cap_rs1, cap_rs2;

   logic                   vld_p1;
   logic [XLEN-1:0]        pc_p1;
   logic signed [XLEN-1:0] imm_p1, rs1_val_p1, rs2_val_p1;
   logic [REG_ADDR_W-1:0]  rs1_p1, rs2_p1, rd_p1;
   logic [6:0]             opcode_p1, funct7_p1;
   logic [2:0]             funct3_p1;
   logic                   is_load_p1, illegal_p1;
   logic [CNT_W-1:0]       cnt_stall;

   assign inst  = bus.in_inst;
   assign opc   = inst[6:0];
   assign rs1_a = REG_ADDR_W'(inst[19:15]);
   assign rs2_a = REG_ADDR_W'(inst[24:20]);
   assign rd_a  = REG_ADDR_W'(inst[11:7]);

   // Only R/S/B formats actually read rs2, so only they can stall on it.
   assign uses_rs2 = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
   assign hazard   = vld_p1 && is_load_p1 && (rd_p1 != '0) &&
                     ((rs1_a == rd_p1) || (uses_rs2 && (rs2_a == rd_p1)));
   assign ready    = (!vld_p1 || bus.out_ready) && !hazard && !bus.flush;
   assign accept   = bus.in_valid && ready;

`ifdef ID_WB_BYPASS_EN
   assign cap_rs1 = wb_hit(bus.wb_we, bus.wb_rd, rs1_a) ? bus.wb_data : bus.rdata1;
   assign cap_rs2 = wb_hit(bus.wb_we, bus.wb_rd, rs2_a) ? bus.wb_data : bus.rdata2;
`else
   logic unused_wb;
   assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};
   assign cap_rs1   = bus.rdata1;
   assign cap_rs2   = bus.rdata2;
`endif

   // Stage p1: decoded instruction register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         pc_p1      <= '0;
         imm_p1     <= '0;
         rs1_val_p1 <= '0;
         rs2_val_p1 <= '0;
         rs1_p1     <= '0;
         rs2_p1     <= '0;
         rd_p1      <= '0;
         opcode_p1  <= '0;
         funct3_p1  <= '0;
         funct7_p1  <= '0;
         is_load_p1 <= 1'b0;
         illegal_p1 <= 1'b0;
         cnt_stall  <= '0;
      end else begin
         if (bus.flush) begin
            vld_p1 <= 1'b0;
         end else if (accept) begin
            vld_p1     <= 1'b1;
            pc_p1      <= bus.in_pc;
            imm_p1     <= imm_gen(inst);
            rs1_val_p1 <= cap_rs1;
            rs2_val_p1 <= cap_rs2;
            rs1_p1     <= rs1_a;
            rs2_p1     <= rs2_a;
            rd_p1      <= rd_a;
            opcode_p1  <= opc;
            funct3_p1  <= inst[14:12];
            funct7_p1  <= inst[31:25];
            is_load_p1 <= (opc == OPC_LOAD);
            illegal_p1 <= is_illegal(inst);
         end else if (vld_p1 && bus.out_ready) begin
            vld_p1 <= 1'b0;
         end
`ifdef ID_WB_BYPASS_EN
         if (vld_p1 && !accept) begin
            if (wb_hit(bus.wb_we, bus.wb_rd, rs1_p1)) rs1_val_p1 <= bus.wb_data;
            if (wb_hit(bus.wb_we, bus.wb_rd, rs2_p1)) rs2_val_p1 <= bus.wb_data;
         end
`endif
         if (bus.in_valid && hazard && !bus.flush) cnt_stall <= sat_inc(cnt_stall);
      end
   end

   assign bus.in_ready    = ready;
   assign bus.raddr1      = rs1_a;
   assign bus.raddr2      = rs2_a;
   assign bus.out_valid   = vld_p1;
   assign bus.out_pc      = pc_p1;
   assign bus.out_imm     = imm_p1;
   assign bus.out_rs1_val = rs1_val_p1;
   assign bus.out_rs2_val = rs2_val_p1;
   assign bus.out_rs1     = rs1_p1;
   assign bus.out_rs2     = rs2_p1;
   assign bus.out_rd      = rd_p1;
   assign bus.out_opcode  = opcode_p1;
   assign bus.out_funct3  = funct3_p1;
   assign bus.out_funct7  = funct7_p1;
   assign bus.out_is_load = is_load_p1;
   assign bus.out_illegal = illegal_p1;
   assign bus.stall_cnt   = cnt_stall;
endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: decode vector table plus handshake/hazard/flush/reset sequences.
module tb_id_pipe_stage;
   localparam int XLEN = 32;
   localparam int RAW  = 5;
   localparam int CW   = 2;

   localparam logic [31:0] I_ADDI = 32'hFFB00093;
   localparam logic [31:0] I_LUI  = 32'h123450B7;
   localparam logic [31:0] I_LW   = 32'h00012283;
   localparam logic [31:0] I_ADD  = 32'h00128333;
   localparam logic [31:0] I_ADX3 = 32'h00118213;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   id_pipe_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CW)) bus ();

   id_pipe_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [6:0]  op;
      logic        ill;
      logic        ld;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_rs1;

   initial begin
      n_vec = 0;
      n_bad = 0;
      vecs[0]  = '{32'hFFB00093, 32'hFFFFFFFB, 5'd1,  7'h13, 1'b0, 1'b0};
      vecs[1]  = '{32'h123450B7, 32'h12345000, 5'd1,  7'h37, 1'b0, 1'b0};
      vecs[2]  = '{32'h0000007F, 32'h00000000, 5'd0,  7'h7F, 1'b1, 1'b0};
      vecs[3]  = '{32'h00512423, 32'h00000008, 5'd8,  7'h23, 1'b0, 1'b0};
      vecs[4]  = '{32'hFE512E23, 32'hFFFFFFFC, 5'd28, 7'h23, 1'b0, 1'b0};
      vecs[5]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd25, 7'h63, 1'b0, 1'b0};
      vecs[6]  = '{32'h001000EF, 32'h00000800, 5'd1,  7'h6F, 1'b0, 1'b0};
      vecs[7]  = '{32'h00012283, 32'h00000000, 5'd5,  7'h03, 1'b0, 1'b1};
      vecs[8]  = '{32'h00000000, 32'h00000000, 5'd0,  7'h00, 1'b1, 1'b0};
      vecs[9]  = '{32'h0000000F, 32'h00000000, 5'd0,  7'h0F, 1'b0, 1'b0};
      vecs[10] = '{32'h80000197, 32'h80000000, 5'd3,  7'h17, 1'b0, 1'b0};

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
      bus.rdata1 = '0; bus.rdata2 = '0;
      bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
      #12;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_stall_cnt", bus.stall_cnt, 0);
      chk("rst_out_imm", bus.out_imm, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_out_illegal", bus.out_illegal, 0);
      chk("rst_out_is_load", bus.out_is_load, 0);
      bus.in_inst = I_ADD;
      #1;
      chk("raddr1_comb", bus.raddr1, 5);
      chk("raddr2_comb", bus.raddr2, 1);
      rst_n = 1'b1;

      // load-use pair: one bubble, one stall count
      bus.in_valid = 1'b1; bus.in_inst = I_LW; bus.in_pc = 32'h40;
      #1 chk("lu_ready_lw", bus.in_ready, 1);
      step();
      chk("lu_valid_lw", bus.out_valid, 1);
      chk("lu_is_load", bus.out_is_load, 1);
      bus.in_inst = I_ADD; bus.in_pc = 32'h44;
      #1 chk("lu_ready_hazard", bus.in_ready, 0);
      step();
      chk("lu_bubble", bus.out_valid, 0);
      chk("lu_stall_cnt", bus.stall_cnt, 1);
      chk("lu_ready_after", bus.in_ready, 1);
      step();
      chk("lu_valid_add", bus.out_valid, 1);
      chk("lu_rd_add", bus.out_rd, 6);
      chk("lu_pc_add", bus.out_pc, 32'h44);

      // held load with a stalled consumer: counter saturates
      bus.in_inst = I_LW; bus.in_pc = 32'h48;
      step();
      bus.out_ready = 1'b0; bus.in_inst = I_ADD; bus.in_pc = 32'h4C;
      step();
      chk("sat_cnt2", bus.stall_cnt, 2);
      step();
      chk("sat_cnt3", bus.stall_cnt, 3);
      step();
      step();
      chk("sat_hold", bus.stall_cnt, 3);
      chk("sat_pc_held", bus.out_pc, 32'h48);
      bus.out_ready = 1'b1;
      step();
      chk("sat_bubble", bus.out_valid, 0);
      step();
      chk("sat_add_pc", bus.out_pc, 32'h4C);
      bus.in_valid = 1'b0;
      step();

      // decode table
      for (int i = 0; i < 11; i++) begin
         bus.in_valid = 1'b1; bus.in_inst = vecs[i].inst; bus.in_pc = 32'h1000 + 32'(4 * i);
         bus.rdata1 = 32'hA000_0000 + 32'(i); bus.rdata2 = 32'hB000_0000 + 32'(i);
         step();
         chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
         chk($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
         chk($sformatf("v%0d_rd", i), bus.out_rd, vecs[i].rd);
         chk($sformatf("v%0d_opcode", i), bus.out_opcode, vecs[i].op);
         chk($sformatf("v%0d_illegal", i), bus.out_illegal, vecs[i].ill);
         chk($sformatf("v%0d_is_load", i), bus.out_is_load, vecs[i].ld);
         chk($sformatf("v%0d_pc", i), bus.out_pc, 32'h1000 + 32'(4 * i));
         chk($sformatf("v%0d_rs1_val", i), bus.out_rs1_val, 32'hA000_0000 + 32'(i));
         chk($sformatf("v%0d_rs2_val", i), bus.out_rs2_val, 32'hB000_0000 + 32'(i));
         bus.in_valid = 1'b0;
         step();
      end
      chk("tbl_stall_cnt", bus.stall_cnt, 3);

      // backpressure for three cycles
      bus.in_valid = 1'b1; bus.in_inst = I_ADDI; bus.in_pc = 32'h100;
      step();
      bus.out_ready = 1'b0; bus.in_inst = I_LUI; bus.in_pc = 32'h104;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_ready_low", bus.in_ready, 0);
         step();
         chk("bp_pc_stable", bus.out_pc, 32'h100);
         chk("bp_imm_stable", bus.out_imm, 32'hFFFFFFFB);
      end
      bus.out_ready = 1'b1;
      #1 chk("bp_ready_release", bus.in_ready, 1);
      step();
      chk("bp_next_pc", bus.out_pc, 32'h104);
      chk("bp_next_imm", bus.out_imm, 32'h12345000);
      bus.in_valid = 1'b0;
      step();

      // flush kills held and offered instruction
      bus.in_valid = 1'b1; bus.in_inst = I_ADDI; bus.in_pc = 32'h200;
      step();
      bus.in_inst = I_LUI; bus.in_pc = 32'h204; bus.flush = 1'b1; bus.out_ready = 1'b0;
      #1 chk("fl_ready", bus.in_ready, 0);
      step();
      chk("fl_valid", bus.out_valid, 0);
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      step();
      chk("fl_still_idle", bus.out_valid, 0);
      chk("fl_pc_kept", bus.out_pc, 32'h200);

      // writeback bypass at capture and while held
      bus.in_valid = 1'b1; bus.in_inst = I_ADX3; bus.in_pc = 32'h300; bus.rdata1 = 32'h1111;
      bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hA5;
`ifdef ID_WB_BYPASS_EN
      exp_rs1 = 32'hA5;
`else
      exp_rs1 = 32'h1111;
`endif
      step();
      chk("byp_capture", bus.out_rs1_val, exp_rs1);
      bus.in_valid = 1'b0; bus.wb_data = 32'h77;
`ifdef ID_WB_BYPASS_EN
      exp_rs1 = 32'h77;
`endif
      step();
      chk("byp_held", bus.out_rs1_val, exp_rs1);
      chk("byp_still_valid", bus.out_valid, 1);
      bus.wb_we = 1'b0;

      // asynchronous reset while holding
      rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_pc", bus.out_pc, 0);
      chk("arst_rs1_val", bus.out_rs1_val, 0);
      chk("arst_stall_cnt", bus.stall_cnt, 0);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      step();
      chk("arst_idle", bus.out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Registered RV32I decode stage with a valid/ready handshake on both sides, parametrised datapath width. It sits between the fetch stage and the execute stage. It does the following:
- extracts instruction fields and the sign-extended immediate;
- captures register-file operands;
- flags illegal opcodes;
- inserts a one-cycle bubble on a load-use hazard.

A stall counter is provided for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width; immediates sign-extend to XLEN, U-type fills bits XLEN-1:32 with inst[31].
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- raddr1, raddr2  out  REG_ADDR_W  combinational in_inst[19:15], in_inst[24:20] to register file.
- rdata1, rdata2  in  XLEN  register-file read data, same cycle.
- wb_we  in  1  writeback write enable.
- wb_rd  in  REG_ADDR_W  writeback destination.
- wb_data  in  XLEN  writeback data.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  decoded instruction held.
- out_ready  in  1  execute accepts.
- out_pc, out_imm, out_rs1_val, out_rs2_val  out  XLEN  registered.
- out_rs1, out_rs2, out_rd  out  REG_ADDR_W  registered fields.
- out_opcode  out  7, out_funct3  out  3, out_funct7  out  7  registered fields.
- out_is_load  out  1  opcode 0000011.
- out_illegal  out  1  illegal encoding.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation

**Immediate format by opcode**
- I-type: 0010011, 0000011, 1100111, 1110011, and all other opcodes.
- S-type: 0100011.
- B-type: 1100011.
- U-type: 0110111, 0010111.
- J-type: 1101111.

**Illegal flag**
- out_illegal=1 when inst[1:0]!=2'b11, or when the opcode is not one of 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 1110011, 0001111.
- An illegal instruction still flows with out_valid=1.

**Hazard**
- hazard = out_valid & out_is_load & out_rd!=0 & (in_inst rs1==out_rd | (in_inst rs2==out_rd & in opcode in {0110011, 0100011, 1100011})).

**Handshake**
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready): load all out_* fields, set out_valid=1.
- Else, if out_valid & out_ready: clear out_valid. This is a bubble when caused by hazard.
- flush: clear out_valid next edge; the incoming instruction is dropped; flush has priority over everything.
- Data fields keep their last values when out_valid=0.

**Stall counter**
- stall_cnt increments when in_valid & hazard & !flush.
- Saturates at all-ones.

## Timing
- Latency 1 cycle from accept to out_valid.
- Full throughput when out_ready stays high and there is no hazard.
- A load-use pair costs exactly one bubble cycle: the load leaves, out_valid=0 for one cycle, then the consumer is accepted.
- Reset (async assert, sync to clk on deassert internally not required):
  - out_valid=0, stall_cnt=0.
  - All data outputs 0, including out_illegal=0 and out_is_load=0.
- Reset mid-transfer discards the held instruction.
- Simultaneous out_ready and accept: the held instruction is transferred and the new one is loaded on the same edge.
- raddr1/raddr2 are purely combinational from in_inst regardless of in_valid.

## Configuration
Macro: ID_WB_BYPASS_EN.

Defined:
- At capture, if wb_we & wb_rd!=0 & wb_rd==rs1 (or rs2), the captured operand is wb_data instead of rdata.
- While held (out_valid=1, not loading), out_rs1_val/out_rs2_val are overwritten with wb_data when wb_we & wb_rd!=0 matches out_rs1/out_rs2.

Undefined:
- Operands are always rdata1/rdata2 captured at accept and never updated while held.

## Test plan
- Reset then `addi x1,x0,-5` (0xFFB00093) with out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFB, out_rd=1, out_illegal=0.
- `lw x5,0(x2)` followed by `add x6,x5,x1` back-to-back → in_ready=0 for one cycle, one out_valid=0 bubble, stall_cnt=1.
- out_ready=0 for 3 cycles with in_valid=1 → out_* stable, in_ready=0; release → next instruction accepted the same edge.
- flush asserted while holding an instruction and offering another → out_valid=0 next cycle, neither instruction emitted.
- Instruction 0x0000007F → out_illegal=1. `lui` 0x123450B7 → out_imm=0x12345000.
- With ID_WB_BYPASS_EN: accept rs1=x3 while wb_we=1, wb_rd=3, wb_data=0xA5 → out_rs1_val=0xA5; without the macro → rdata1 value.
